// File: rtl/bcd_convert_arbiter.sv
// Two-requester arbiter in front of a serial double-dabble binary-to-BCD converter.
// One 8-bit operand is converted per grant; the result is strobed back with ack/valid.
module bcd_convert_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] bin0,
    input  logic       req1,
    input  logic [7:0] bin1,
    output logic       ack0,
    output logic       ack1,
    output logic       busy,
    output logic       grant_id,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       valid,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [7:0]  opnd_q;
    logic [11:0] dig_q;
    logic        last_q;
    logic        grant_q;
    logic        ack0_q;
    logic        ack1_q;
    logic        valid_q;
    logic        busy_q;
    logic [11:0] res_q;

    logic        win_d;
    logic [11:0] adj_d;
    logic [11:0] shift_d;

    // Handshake: a requester holds req until its one-cycle ack; the result digits
    // are valid in that same cycle and remain held until the next conversion ends.
    always_comb begin
        win_d = 1'b0;
        if (req0 && req1) begin
            win_d = FIXED_PRIORITY ? 1'b0 : ~last_q;
        end else if (req1) begin
            win_d = 1'b1;
        end
    end

    // Digits never exceed 12 after the +3 correction, so no carry crosses a digit.
    always_comb begin
        adj_d = dig_q + {(dig_q[11:8] >= 4'd5) ? 4'd3 : 4'd0,
                         (dig_q[7:4]  >= 4'd5) ? 4'd3 : 4'd0,
                         (dig_q[3:0]  >= 4'd5) ? 4'd3 : 4'd0};
        shift_d = (adj_d << 1) | {11'd0, opnd_q[cnt_q]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            opnd_q  <= 8'd0;
            dig_q   <= 12'd0;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            res_q   <= 12'd0;
        end else begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_q <= win_d;
                        last_q  <= win_d;
                        opnd_q  <= win_d ? bin1 : bin0;
                        cnt_q   <= 3'd7;
                        dig_q   <= 12'd0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    dig_q <= shift_d;
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd0) begin
                        res_q   <= shift_d;
                        ack0_q  <= ~grant_q;
                        ack1_q  <= grant_q;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign valid       = valid_q;
    assign busy        = busy_q;
    assign grant_id    = grant_q;
    assign hundreds    = res_q[11:8];
    assign tens        = res_q[7:4];
    assign ones        = res_q[3:0];
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Directed bench for bcd_convert_arbiter: vector table, arbitration, reset abort, full sweep.
module tb_bcd_convert_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       req0, req1, ack0, ack1, busy, grant_id, valid;
    logic [7:0] bin0, bin1;
    logic [3:0] hundreds, tens, ones;
    logic [1:0] dbg_state;

    logic       f_req0, f_req1, f_ack0, f_ack1, f_busy, f_grant_id, f_valid;
    logic [7:0] f_bin0, f_bin1;
    logic [3:0] f_hundreds, f_tens, f_ones;
    logic [1:0] f_dbg_state;

    bcd_convert_arbiter #(.FIXED_PRIORITY(1'b0)) dut_rr (
        .clk(clk), .reset(reset),
        .req0(req0), .bin0(bin0), .req1(req1), .bin1(bin1),
        .ack0(ack0), .ack1(ack1), .busy(busy), .grant_id(grant_id),
        .hundreds(hundreds), .tens(tens), .ones(ones), .valid(valid),
        .dbg_state_o(dbg_state)
    );

    bcd_convert_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
        .clk(clk), .reset(reset),
        .req0(f_req0), .bin0(f_bin0), .req1(f_req1), .bin1(f_bin1),
        .ack0(f_ack0), .ack1(f_ack1), .busy(f_busy), .grant_id(f_grant_id),
        .hundreds(f_hundreds), .tens(f_tens), .ones(f_ones), .valid(f_valid),
        .dbg_state_o(f_dbg_state)
    );

    typedef struct {
        bit         sel;
        logic [7:0] bin;
        logic [3:0] h, t, o;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int ack1_cnt = 0;
    int viol = 0;

    always @(negedge clk) begin
        if (ack1) ack1_cnt++;
        if (((ack0 | ack1 | valid) && !busy) || (ack0 && ack1) ||
            ((f_ack0 | f_ack1 | f_valid) && !f_busy) || (f_ack0 && f_ack1))
            viol++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input bit fp, output int lat);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (fp ? (f_ack0 | f_ack1) : (ack0 | ack1)) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        if (v.sel) begin req1 = 1'b1; bin1 = v.bin; end
        else       begin req0 = 1'b1; bin0 = v.bin; end
        @(posedge clk);
        wait_ack(1'b0, lat);
        check({tag, " latency"}, lat, 9);
        check({tag, " acks"}, {ack1, ack0}, v.sel ? 2'b10 : 2'b01);
        check({tag, " valid/busy/grant"}, {valid, busy, grant_id}, {2'b11, v.sel});
        check({tag, " digits"}, {hundreds, tens, ones}, {v.h, v.t, v.o});
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check({tag, " after done"}, {valid, busy, ack1, ack0, hundreds, tens, ones},
              {4'b0000, v.h, v.t, v.o});
    endtask

    vec_t vecs[10];

    initial begin
        int lat;
        int seen;
        int cnt0;
        vec_t v;
        logic [7:0] fp_ops[3];
        logic [11:0] fp_exp[3];

        vecs[0] = '{1'b0, 8'd255, 4'd2, 4'd5, 4'd5};
        vecs[1] = '{1'b0, 8'd0,   4'd0, 4'd0, 4'd0};
        vecs[2] = '{1'b0, 8'd99,  4'd0, 4'd9, 4'd9};
        vecs[3] = '{1'b0, 8'd100, 4'd1, 4'd0, 4'd0};
        vecs[4] = '{1'b1, 8'd1,   4'd0, 4'd0, 4'd1};
        vecs[5] = '{1'b1, 8'd9,   4'd0, 4'd0, 4'd9};
        vecs[6] = '{1'b1, 8'd10,  4'd0, 4'd1, 4'd0};
        vecs[7] = '{1'b1, 8'd199, 4'd1, 4'd9, 4'd9};
        vecs[8] = '{1'b1, 8'd200, 4'd2, 4'd0, 4'd0};
        vecs[9] = '{1'b0, 8'd128, 4'd1, 4'd2, 4'd8};

        req0 = 0; req1 = 0; bin0 = 0; bin1 = 0;
        f_req0 = 0; f_req1 = 0; f_bin0 = 0; f_bin1 = 0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("reset state", {ack0, ack1, valid, busy, grant_id, hundreds, tens, ones, dbg_state}, 0);
        check("reset state fp", {f_ack0, f_ack1, f_valid, f_busy, f_grant_id, f_hundreds, f_tens, f_ones}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Operand changed and req dropped right after the grant edge.
        @(negedge clk);
        req0 = 1'b1; bin0 = 8'd99;
        @(posedge clk);
        #1 bin0 = 8'd0; req0 = 1'b0;
        wait_ack(1'b0, lat);
        check("hold latency", lat, 9);
        check("hold result", {ack1, ack0, hundreds, tens, ones}, {2'b01, 12'h099});
        @(negedge clk);
        check("hold idle", {busy, valid}, 0);

        // Reset mid-SHIFT aborts with no ack and clears the held result.
        @(negedge clk);
        req1 = 1'b1; bin1 = 8'd200;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 bin1 = 8'd7;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1; req1 = 1'b0;
        #1;
        check("async abort", {ack0, ack1, valid, busy, hundreds, tens, ones, dbg_state}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (ack0 | ack1 | valid | busy) seen++;
        end
        check("no ack after abort", seen, 0);
        v = '{1'b1, 8'd200, 4'd2, 4'd0, 4'd0};
        run_vec(v, "post reset");

        // Simultaneous requests after reset: req0 first, req1 ten cycles later.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; bin0 = 8'd123; bin1 = 8'd45;
        @(posedge clk);
        wait_ack(1'b0, lat);
        check("tie first latency", lat, 9);
        check("tie first", {ack1, ack0, grant_id, hundreds, tens, ones}, {3'b010, 12'h123});
        req0 = 1'b0;
        wait_ack(1'b0, lat);
        check("tie second spacing", lat, 10);
        check("tie second", {ack1, ack0, grant_id, hundreds, tens, ones}, {3'b101, 12'h045});
        req1 = 1'b0;
        @(negedge clk);

        // Fixed priority: req0 held high, req1 starved.
        fp_ops[0] = 8'd37;  fp_exp[0] = 12'h037;
        fp_ops[1] = 8'd64;  fp_exp[1] = 12'h064;
        fp_ops[2] = 8'd215; fp_exp[2] = 12'h215;
        @(negedge clk);
        f_req0 = 1'b1; f_req1 = 1'b1; f_bin0 = fp_ops[0]; f_bin1 = 8'd250;
        @(posedge clk);
        for (int r = 0; r < 3; r++) begin
            wait_ack(1'b1, lat);
            check($sformatf("fp%0d latency", r), lat, (r == 0) ? 9 : 10);
            check($sformatf("fp%0d grant", r), {f_ack1, f_ack0, f_grant_id, f_valid,
                  f_hundreds, f_tens, f_ones}, {4'b0101, fp_exp[r]});
            if (r < 2) f_bin0 = fp_ops[r + 1];
        end
        f_req0 = 1'b0; f_req1 = 1'b0;
        @(negedge clk);

        // Full operand sweep on requester 1.
        for (int b = 0; b < 256; b++) begin
            logic [3:0] eh, et, eo;
            logic [7:0] nacks;
            eh = 4'(b / 100);
            et = 4'((b / 10) % 10);
            eo = 4'(b % 10);
            cnt0 = ack1_cnt;
            @(negedge clk);
            req1 = 1'b1; bin1 = 8'(b);
            @(posedge clk);
            wait_ack(1'b0, lat);
            req1 = 1'b0;
            @(negedge clk);
            nacks = 8'(ack1_cnt - cnt0);
            check($sformatf("sweep %0d", b), {hundreds, tens, ones, nacks}, {eh, et, eo, 8'd1});
        end

        check("protocol violations", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_convert_arbiter.md
BCD_CONVERT_ARBITER -- requirements
Module: bcd_convert_arbiter

Interface
REQ-001 Parameter: FIXED_PRIORITY, default 0, arbitration mode: 0 = round-robin, 1 = requester 0 always wins.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req0  input  1  requester 0 conversion request; held high until ack0.
REQ-005 Port: bin0  input  8  requester 0 unsigned binary operand.
REQ-006 Port: req1  input  1  requester 1 conversion request; held high until ack1.
REQ-007 Port: bin1  input  8  requester 1 unsigned binary operand.
REQ-008 Port: ack0 / ack1  output  1 each  one-cycle result strobe to the granted requester.
REQ-009 Port: busy  output  1  high in SHIFT and DONE states.
REQ-010 Port: grant_id  output  1  requester currently or most recently granted.
REQ-011 Port: hundreds / tens / ones  output  4 each  registered BCD result digits.
REQ-012 Port: valid  output  1  high for the one cycle that the result digits are new.

Function
REQ-013 The block SHALL be a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 IDLE, no request: SHALL stay in IDLE with all outputs held.
REQ-015 IDLE, any req sampled high at edge E0: SHALL latch the winning operand, set grant_id, load bit counter = 7, clear the internal digit registers, and go to SHIFT.
REQ-016 Round-robin (FIXED_PRIORITY=0): single request wins outright; on simultaneous requests, the requester not granted last wins.
REQ-017 Fixed priority (FIXED_PRIORITY=1): req0 wins over req1 on every simultaneous request.
REQ-018 SHIFT, each edge E1..E8: add 3 to each internal digit >= 5, then shift the {hundreds,tens,ones} chain left one bit, inserting operand bit[counter] at the LSB; decrement counter.
REQ-019 On the edge processing counter==0 (E8): SHALL copy the internal digits to the output registers and go to DONE.
REQ-020 DONE, the cycle after E8: ack of grant_id SHALL be 1, the other ack 0, valid 1; at E9, return to IDLE.
REQ-021 Latency: grant edge E0 to ack/valid high = 9 cycles; minimum spacing between grants = 10 cycles.
REQ-022 Operand changes after E0 SHALL NOT affect the result.
REQ-023 A req deasserted during SHIFT SHALL NOT abort the conversion; ack is still issued.
REQ-024 Requests sampled in SHIFT or DONE SHALL be ignored (not queued); the requester must hold req until acked.
REQ-025 The requester SHALL deassert req by the edge ending its ack cycle (E9); a req still high at E10 is treated as a new request.
REQ-026 Output digits SHALL hold the last result between conversions; each digit is always 0-9 for operands 0-255; hundreds <= 2.
REQ-027 ack0 and ack1 SHALL never be high simultaneously; ack and valid SHALL never be high outside DONE.

Reset
REQ-028 While reset is high, all of the following SHALL hold immediately, without waiting for a clock: state = IDLE; ack0 = ack1 = valid = busy = 0; hundreds = tens = ones = 0; grant_id = 0; round-robin last-grant = 1 (so req0 wins the first tie).
REQ-029 Reset asserted mid-SHIFT or mid-DONE SHALL abort the conversion with no ack; the first post-reset grant follows REQ-015 normally.

Verification
REQ-030 req0=1, bin0=255, req1=0 -> 9 cycles after grant: ack0=1, valid=1, hundreds=2, tens=5, ones=5; busy low after E9.
REQ-031 bin0=0, then bin0=99, then bin0=100 in separate requests -> results 0/0/0, 0/9/9, 1/0/0.
REQ-032 After reset, req0 and req1 high together with bin0=123 and bin1=45, round-robin -> ack0 with 1/2/3 first, then ack1 with 0/4/5 after 10 more cycles; no overlapping acks.
REQ-033 FIXED_PRIORITY=1, req0 and req1 both held high, req0 re-requesting -> req0 served repeatedly and req1 starved, with grant_id = 0 on every grant.
REQ-034 Grant bin1=200, change bin1 to 7 at E3, then assert reset at E5 for 1 cycle -> no ack, outputs 0, busy 0; the next request converts normally.
REQ-035 Exhaustive sweep of 0-255 on req1 -> every result equals the operand's decimal value, with exactly one ack1 per request.
